// File: rtl/ysyx_23060240_trap_ctrl.sv
// rtl/ysyx_23060240_trap_ctrl.sv - Sequences CSR read-modify-write, ecall trap entry and mret return.
module ysyx_23060240_trap_ctrl #(
  parameter logic [31:0] MCAUSE_ECALL = 32'hb,
  parameter logic [11:0] MTVEC_ADDR   = 12'h305,
  parameter logic [11:0] MEPC_ADDR    = 12'h341,
  parameter logic [11:0] MCAUSE_ADDR  = 12'h342
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inst_valid,
  output logic        inst_ready,
  input  logic [31:0] pc,
  input  logic        is_ecall,
  input  logic        is_mret,
  input  logic        is_csr,
  input  logic [1:0]  csr_op,
  input  logic [11:0] csr_addr,
  input  logic [31:0] rs1_data,
  output logic        csr_ren,
  output logic [11:0] csr_raddr,
  input  logic [31:0] csr_rdata,
  output logic        csr_wen,
  output logic [11:0] csr_waddr,
  output logic [31:0] csr_wdata,
  output logic        rd_wen,
  output logic [31:0] rd_wdata,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, CSR_RD, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_VEC, MRET_RD, REDIRECT
  } state_t;

  state_t      state;
  logic [11:0] addr_q;
  logic [1:0]  op_q;
  logic [31:0] rs1_q;
  logic [31:0] csr_new;

  always_comb begin
    csr_new = 32'h0;
    case (op_q)
      2'b01:   csr_new = rs1_q;
      2'b10:   csr_new = csr_rdata | rs1_q;
      2'b11:   csr_new = csr_rdata & ~rs1_q;
      default: csr_new = 32'h0;
    endcase
  end

  // Outputs are registered for the state being entered, so each enable covers
  // exactly the cycle spent in its state; strobes default back to zero each edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      addr_q         <= 12'h0;
      op_q           <= 2'b00;
      rs1_q          <= 32'h0;
      inst_ready     <= 1'b0;
      busy           <= 1'b0;
      csr_ren        <= 1'b0;
      csr_raddr      <= 12'h0;
      csr_wen        <= 1'b0;
      csr_waddr      <= 12'h0;
      csr_wdata      <= 32'h0;
      rd_wen         <= 1'b0;
      rd_wdata       <= 32'h0;
      redirect_valid <= 1'b0;
      redirect_pc    <= 32'h0;
    end else begin
      csr_ren   <= 1'b0;
      csr_raddr <= 12'h0;
      csr_wen   <= 1'b0;
      csr_waddr <= 12'h0;
      csr_wdata <= 32'h0;
      rd_wen    <= 1'b0;
      rd_wdata  <= 32'h0;
      case (state)
        IDLE: begin
          inst_ready <= 1'b1;
          if (inst_valid && inst_ready) begin
            addr_q <= csr_addr;
            op_q   <= csr_op;
            rs1_q  <= rs1_data;
            if (is_ecall) begin
              state      <= TRAP_EPC;
              inst_ready <= 1'b0;
              busy       <= 1'b1;
              csr_wen    <= 1'b1;
              csr_waddr  <= MEPC_ADDR;
              csr_wdata  <= pc;
            end else if (is_mret) begin
              state      <= MRET_RD;
              inst_ready <= 1'b0;
              busy       <= 1'b1;
              csr_ren    <= 1'b1;
              csr_raddr  <= MEPC_ADDR;
            end else if (is_csr) begin
              state      <= CSR_RD;
              inst_ready <= 1'b0;
              busy       <= 1'b1;
              csr_ren    <= 1'b1;
              csr_raddr  <= csr_addr;
            end
          end
        end
        CSR_RD: begin
          state    <= CSR_WR;
          rd_wen   <= 1'b1;
          rd_wdata <= csr_rdata;
          if (op_q != 2'b00) begin
            csr_wen   <= 1'b1;
            csr_waddr <= addr_q;
            csr_wdata <= csr_new;
          end
        end
        CSR_WR: begin
          state      <= IDLE;
          inst_ready <= 1'b1;
          busy       <= 1'b0;
        end
        TRAP_EPC: begin
          state     <= TRAP_CAUSE;
          csr_wen   <= 1'b1;
          csr_waddr <= MCAUSE_ADDR;
          csr_wdata <= MCAUSE_ECALL;
        end
        TRAP_CAUSE: begin
          state     <= TRAP_VEC;
          csr_ren   <= 1'b1;
          csr_raddr <= MTVEC_ADDR;
        end
        TRAP_VEC, MRET_RD: begin
          state          <= REDIRECT;
          redirect_valid <= 1'b1;
          redirect_pc    <= csr_rdata;
        end
        REDIRECT: begin
          if (redirect_ready) begin
            state          <= IDLE;
            inst_ready     <= 1'b1;
            busy           <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'h0;
          end
        end
        default: begin
          state      <= IDLE;
          inst_ready <= 1'b0;
          busy       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060240_trap_ctrl.sv
// tb/tb_ysyx_23060240_trap_ctrl.sv - Directed-vector bench for the trap/CSR sequencer.
module tb_ysyx_23060240_trap_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] pc = 32'h0;
  logic        is_ecall = 1'b0, is_mret = 1'b0, is_csr = 1'b0;
  logic [1:0]  csr_op = 2'b00;
  logic [11:0] csr_addr = 12'h0;
  logic [31:0] rs1_data = 32'h0;
  logic        csr_ren;
  logic [11:0] csr_raddr;
  logic [31:0] csr_rdata;
  logic        csr_wen;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        rd_wen;
  logic [31:0] rd_wdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready = 1'b0;
  logic        busy;

  int total = 0;
  int bad = 0;

  logic [31:0] mtvec, mepc, mcause;
  int          mcause_writes;

  ysyx_23060240_trap_ctrl dut (
    .clk(clk), .rst_n(rst_n), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .pc(pc), .is_ecall(is_ecall), .is_mret(is_mret), .is_csr(is_csr),
    .csr_op(csr_op), .csr_addr(csr_addr), .rs1_data(rs1_data),
    .csr_ren(csr_ren), .csr_raddr(csr_raddr), .csr_rdata(csr_rdata),
    .csr_wen(csr_wen), .csr_waddr(csr_waddr), .csr_wdata(csr_wdata),
    .rd_wen(rd_wen), .rd_wdata(rd_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  // Minimal CSR file: three implemented registers, everything else reads 0.
  assign csr_rdata = (csr_raddr == 12'h305) ? mtvec :
                     (csr_raddr == 12'h341) ? mepc :
                     (csr_raddr == 12'h342) ? mcause : 32'h0;

  always @(posedge clk) begin
    if (csr_wen) begin
      case (csr_waddr)
        12'h305: mtvec <= csr_wdata;
        12'h341: mepc <= csr_wdata;
        12'h342: begin mcause <= csr_wdata; mcause_writes <= mcause_writes + 1; end
        default: ;
      endcase
    end
  end

  // Offer one instruction at a negedge; returns at the negedge of cycle 1
  // with the fields scrambled so later changes must not matter.
  task automatic offer(input logic e, input logic m, input logic c, input logic [1:0] op,
                       input logic [11:0] a, input logic [31:0] r, input logic [31:0] p);
    inst_valid = 1'b1; is_ecall = e; is_mret = m; is_csr = c;
    csr_op = op; csr_addr = a; rs1_data = r; pc = p;
    @(negedge clk);
    inst_valid = 1'b0; is_ecall = 1'b0; is_mret = 1'b0; is_csr = 1'b0;
    csr_op = 2'b11; csr_addr = 12'hfff; rs1_data = 32'hdead_beef; pc = 32'h1234_5678;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    total++; if (inst_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got %b want 0", inst_ready); end
    total++; if ({busy, csr_wen, csr_ren, rd_wen, redirect_valid} !== 5'b0) begin bad++; $display("FAIL reset_outs got %b want 00000", {busy, csr_wen, csr_ren, rd_wen, redirect_valid}); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (inst_ready !== 1'b1) begin bad++; $display("FAIL release_ready got %b want 1", inst_ready); end
  endtask

  task automatic test_csrrw();
    mtvec = 32'h0;
    offer(1'b0, 1'b0, 1'b1, 2'b01, 12'h305, 32'h8000_0100, 32'h0);
    total++; if ({csr_ren, csr_raddr, rd_wen, csr_wen} !== {1'b1, 12'h305, 1'b0, 1'b0}) begin bad++; $display("FAIL rw_c1 got ren=%b raddr=%h rdw=%b wen=%b want 1 305 0 0", csr_ren, csr_raddr, rd_wen, csr_wen); end
    @(negedge clk);
    total++; if ({rd_wen, rd_wdata} !== {1'b1, 32'h0}) begin bad++; $display("FAIL rw_rd got %b %h want 1 0", rd_wen, rd_wdata); end
    total++; if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h305, 32'h8000_0100}) begin bad++; $display("FAIL rw_wr got %b %h %h want 1 305 80000100", csr_wen, csr_waddr, csr_wdata); end
    total++; if ({csr_ren, csr_raddr, inst_ready, busy} !== {1'b0, 12'h0, 1'b0, 1'b1}) begin bad++; $display("FAIL rw_c2_misc got %b %h %b %b want 0 000 0 1", csr_ren, csr_raddr, inst_ready, busy); end
    @(negedge clk);
    total++; if ({rd_wen, csr_wen, inst_ready, busy, mtvec} !== {4'b0010, 32'h8000_0100}) begin bad++; $display("FAIL rw_c3 got %b%b%b%b %h want 0010 80000100", rd_wen, csr_wen, inst_ready, busy, mtvec); end
  endtask

  task automatic test_csrrs_rc();
    mepc = 32'hF0;
    offer(1'b0, 1'b0, 1'b1, 2'b10, 12'h341, 32'h0F, 32'h0);
    @(negedge clk);
    total++; if ({csr_wdata, rd_wdata} !== {32'hFF, 32'hF0}) begin bad++; $display("FAIL rs got wdata=%h rd=%h want ff f0", csr_wdata, rd_wdata); end
    @(negedge clk);
    offer(1'b0, 1'b0, 1'b1, 2'b11, 12'h341, 32'hF0, 32'h0);
    @(negedge clk);
    total++; if ({csr_wen, csr_waddr, csr_wdata, rd_wdata} !== {1'b1, 12'h341, 32'h0F, 32'hFF}) begin bad++; $display("FAIL rc got wen=%b %h wdata=%h rd=%h want 1 341 0f ff", csr_wen, csr_waddr, csr_wdata, rd_wdata); end
    @(negedge clk);
  endtask

  task automatic test_csr_readonly();
    mcause = 32'h5;
    offer(1'b0, 1'b0, 1'b1, 2'b00, 12'h342, 32'hFFFF_FFFF, 32'h0);
    @(negedge clk);
    total++; if ({rd_wen, rd_wdata, csr_wen, csr_waddr, csr_wdata} !== {1'b1, 32'h5, 1'b0, 12'h0, 32'h0}) begin bad++; $display("FAIL ro got rdw=%b %h wen=%b %h %h want 1 5 0 0 0", rd_wen, rd_wdata, csr_wen, csr_waddr, csr_wdata); end
    @(negedge clk);
    offer(1'b0, 1'b0, 1'b1, 2'b01, 12'h7c0, 32'h1, 32'h0);
    total++; if ({csr_ren, csr_raddr} !== {1'b1, 12'h7c0}) begin bad++; $display("FAIL unimpl_addr got %b %h want 1 7c0", csr_ren, csr_raddr); end
    @(negedge clk);
    total++; if ({rd_wdata, csr_waddr} !== {32'h0, 12'h7c0}) begin bad++; $display("FAIL unimpl_wr got %h %h want 0 7c0", rd_wdata, csr_waddr); end
    @(negedge clk);
  endtask

  task automatic test_ecall();
    mtvec = 32'h8000_0200;
    redirect_ready = 1'b1;
    offer(1'b1, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0, 32'h8000_0040);
    total++; if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h341, 32'h8000_0040}) begin bad++; $display("FAIL ecall_epc got %b %h %h want 1 341 80000040", csr_wen, csr_waddr, csr_wdata); end
    @(negedge clk);
    total++; if ({csr_wen, csr_waddr, csr_wdata} !== {1'b1, 12'h342, 32'hB}) begin bad++; $display("FAIL ecall_cause got %b %h %h want 1 342 b", csr_wen, csr_waddr, csr_wdata); end
    @(negedge clk);
    total++; if ({csr_ren, csr_raddr, csr_wen, redirect_valid} !== {1'b1, 12'h305, 1'b0, 1'b0}) begin bad++; $display("FAIL ecall_vec got %b %h %b %b want 1 305 0 0", csr_ren, csr_raddr, csr_wen, redirect_valid); end
    @(negedge clk);
    total++; if ({redirect_valid, redirect_pc, csr_ren} !== {1'b1, 32'h8000_0200, 1'b0}) begin bad++; $display("FAIL ecall_redir got %b %h %b want 1 80000200 0", redirect_valid, redirect_pc, csr_ren); end
    @(negedge clk);
    total++; if ({redirect_valid, inst_ready, busy, mepc, mcause} !== {3'b010, 32'h8000_0040, 32'hB}) begin bad++; $display("FAIL ecall_done got %b%b%b %h %h want 010 80000040 b", redirect_valid, inst_ready, busy, mepc, mcause); end
    redirect_ready = 1'b0;
  endtask

  task automatic test_mret_stall();
    mepc = 32'h8000_0044;
    offer(1'b0, 1'b1, 1'b0, 2'b00, 12'h0, 32'h0, 32'h0);
    total++; if ({csr_ren, csr_raddr, redirect_valid} !== {1'b1, 12'h341, 1'b0}) begin bad++; $display("FAIL mret_rd got %b %h %b want 1 341 0", csr_ren, csr_raddr, redirect_valid); end
    inst_valid = 1'b1; is_csr = 1'b1; csr_op = 2'b00; csr_addr = 12'h305;
    for (int i = 2; i <= 4; i++) begin
      @(negedge clk);
      total++; if ({redirect_valid, redirect_pc, busy, inst_ready, csr_ren} !== {1'b1, 32'h8000_0044, 3'b100}) begin bad++; $display("FAIL mret_hold c%0d got %b %h %b%b%b want 1 80000044 100", i, redirect_valid, redirect_pc, busy, inst_ready, csr_ren); end
    end
    redirect_ready = 1'b1;
    @(negedge clk);
    redirect_ready = 1'b0;
    total++; if ({redirect_valid, inst_ready, busy, csr_ren} !== 4'b0100) begin bad++; $display("FAIL mret_release got %b%b%b%b want 0100", redirect_valid, inst_ready, busy, csr_ren); end
    @(negedge clk);
    inst_valid = 1'b0; is_csr = 1'b0;
    total++; if ({csr_ren, csr_raddr} !== {1'b1, 12'h305}) begin bad++; $display("FAIL mret_next_accept got %b %h want 1 305", csr_ren, csr_raddr); end
    @(negedge clk); @(negedge clk);
  endtask

  task automatic test_reset_mid();
    mcause = 32'h77;
    mcause_writes = 0;
    offer(1'b1, 1'b0, 1'b0, 2'b00, 12'h0, 32'h0, 32'h8000_0080);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    total++; if ({csr_wen, csr_waddr, csr_wdata, busy, inst_ready} !== {1'b0, 12'h0, 32'h0, 2'b00}) begin bad++; $display("FAIL rstmid_outs got %b %h %h %b%b want 0 0 0 00", csr_wen, csr_waddr, csr_wdata, busy, inst_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    total++; if ({inst_ready, busy, redirect_valid} !== 3'b100) begin bad++; $display("FAIL rstmid_idle got %b want 100", {inst_ready, busy, redirect_valid}); end
    total++; if ({mcause, mepc} !== {32'h77, 32'h8000_0080} || mcause_writes !== 0) begin bad++; $display("FAIL rstmid_csrs got mcause=%h mepc=%h writes=%0d want 77 80000080 0", mcause, mepc, mcause_writes); end
  endtask

  task automatic test_ecall_and_csr();
    int rd_seen;
    mtvec = 32'h8000_0300;
    redirect_ready = 1'b1;
    rd_seen = 0;
    offer(1'b1, 1'b0, 1'b1, 2'b01, 12'h305, 32'h1111_1111, 32'h8000_0010);
    for (int i = 1; i <= 4; i++) begin
      if (rd_wen) rd_seen++;
      if (i < 4) @(negedge clk);
    end
    total++; if (rd_seen !== 0) begin bad++; $display("FAIL both_rdwen got %0d want 0", rd_seen); end
    total++; if ({redirect_valid, redirect_pc, mtvec} !== {1'b1, 32'h8000_0300, 32'h8000_0300}) begin bad++; $display("FAIL both_redir got %b %h mtvec=%h want 1 80000300 80000300", redirect_valid, redirect_pc, mtvec); end
    @(negedge clk);
    redirect_ready = 1'b0;
  endtask

  task automatic test_no_class();
    offer(1'b0, 1'b0, 1'b0, 2'b01, 12'h305, 32'h5, 32'h0);
    total++; if ({inst_ready, busy, csr_ren, csr_wen} !== 4'b1000) begin bad++; $display("FAIL noclass got %b want 1000", {inst_ready, busy, csr_ren, csr_wen}); end
  endtask

  initial begin
    mtvec = 32'h0; mepc = 32'h0; mcause = 32'h0; mcause_writes = 0;
    test_reset();
    test_csrrw();
    test_csrrs_rc();
    test_csr_readonly();
    test_ecall();
    test_mret_stall();
    test_reset_mid();
    test_ecall_and_csr();
    test_no_class();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
endmodule

// File: doc/ysyx_23060240_trap_ctrl.md
YSYX_23060240_TRAP_CTRL -- requirements
Module: ysyx_23060240_trap_ctrl

Interface
REQ-001 SHALL have parameter MCAUSE_ECALL, default 32'hb, mcause value written on ecall.
REQ-002 SHALL have parameter MTVEC_ADDR / MEPC_ADDR / MCAUSE_ADDR, defaults 12'h305 / 12'h341 / 12'h342, CSR addresses used by trap sequences.
REQ-003 SHALL have ports as follows, with one clock and an asynchronous active-low reset:
  clk  in  1  clock, all state updates on posedge;
  rst_n  in  1  asynchronous active-low reset;
  inst_valid  in  1  decoded system instruction offered by IDU;
  inst_ready  out  1  block can accept;
  pc  in  32  PC of offered instruction;
  is_ecall / is_mret / is_csr  in  1 each  instruction class;
  csr_op  in  2  00 read-only, 01 RW, 10 RS, 11 RC;
  csr_addr  in  12  target CSR;
  rs1_data  in  32  operand;
  csr_ren  out  1,  csr_raddr  out  12  read request to CSR file;
  csr_rdata  in  32  combinational read data from CSR file, same cycle;
  csr_wen  out  1,  csr_waddr  out  12,  csr_wdata  out  32  write request to CSR file;
  rd_wen  out  1,  rd_wdata  out  32  GPR writeback of old CSR value;
  redirect_valid  out  1,  redirect_pc  out  32,  redirect_ready  in  1  PC redirect to IFU;
  busy  out  1  state != IDLE.

Function
REQ-004 SHALL implement FSM states IDLE, CSR_RD, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_VEC, MRET_RD, REDIRECT.
REQ-005 SHALL drive inst_ready=1 only in IDLE; accept occurs on posedge with inst_valid&&inst_ready.
REQ-006 SHALL latch pc, csr_addr, csr_op, rs1_data on accept; later input changes SHALL have no effect on the operation.
REQ-007 SHALL decode on accept with priority is_ecall > is_mret > is_csr; none set -> accepted, no action, remain IDLE.
REQ-008 is_csr: IDLE->CSR_RD->CSR_WR->IDLE; CSR_RD drives csr_ren=1, csr_raddr=latched addr, and captures csr_rdata as old.
REQ-009 CSR_WR SHALL drive rd_wen=1, rd_wdata=old, and csr_wen=1 with csr_waddr=latched addr and csr_wdata = rs1 (01), old|rs1 (10), old&~rs1 (11); op 00 -> csr_wen=0.
REQ-010 is_ecall: IDLE->TRAP_EPC (csr_wen, MEPC_ADDR, wdata=latched pc) ->TRAP_CAUSE (csr_wen, MCAUSE_ADDR, wdata=MCAUSE_ECALL) ->TRAP_VEC (csr_ren, MTVEC_ADDR, target<=csr_rdata) ->REDIRECT.
REQ-011 is_mret: IDLE->MRET_RD (csr_ren, MEPC_ADDR, target<=csr_rdata) ->REDIRECT.
REQ-012 REDIRECT SHALL hold redirect_valid=1 and redirect_pc=target stable until redirect_ready=1 is sampled on a posedge, then go to IDLE; redirect_ready high on entry -> exactly one REDIRECT cycle.
REQ-013 Latency from accept edge: CSR op rd_wen in cycle 2; ecall redirect_valid first in cycle 4; mret redirect_valid first in cycle 2.
REQ-014 csr_wen, csr_ren, rd_wen SHALL each be asserted for exactly one full cycle per step and 0 in all other states; address/data outputs SHALL be 0 when the corresponding enable is 0.
REQ-015 Addresses outside the CSR file's implemented set SHALL be issued unchanged; rd_wdata = whatever csr_rdata returned (0 from CSR file).
REQ-016 inst_valid SHALL be ignored while busy=1; redirect_ready SHALL be ignored outside REDIRECT.

Reset
REQ-017 rst_n=0 SHALL asynchronously force IDLE, clear latched operands and target, and drive all outputs 0 (inst_ready=0 while rst_n=0).
REQ-018 Reset mid-sequence SHALL abandon the operation with no further CSR writes; CSR writes already issued are not undone.
REQ-019 After rst_n deasserts, inst_ready=1 from the first posedge.

Verification
REQ-020 CSRRW: accept is_csr, op=01, addr=305, rs1=0x8000_0100, CSR holds 0 -> cycle 2: rd_wen=1 rd_wdata=0, csr_wen=1 waddr=305 wdata=0x8000_0100.
REQ-021 CSRRS then CSRRC on 0x341 holding 0xF0 with rs1=0x0F then 0xF0 -> wdata 0xFF then 0x0F; rd_wdata 0xF0 then 0xFF.
REQ-022 Ecall at pc=0x8000_0040, mtvec=0x8000_0200 -> writes 341=0x8000_0040, 342=0xB in consecutive cycles; cycle 4 redirect_valid=1 redirect_pc=0x8000_0200.
REQ-023 Mret with mepc=0x8000_0044, redirect_ready held 0 for 3 cycles -> redirect_pc stable 0x8000_0044, busy=1, new inst_valid not accepted until the cycle after ready.
REQ-024 rst_n pulsed low during TRAP_CAUSE -> outputs 0 immediately, no mcause write, IDLE with inst_ready=1 after release.
REQ-025 is_ecall and is_csr both set -> ecall sequence only, no rd_wen.
